// File: rtl/rle_word_collector.sv
// rle_word_collector
//   Gathers 16-bit RLE code words from NCH channel coders. Each channel has a
//   one-word holding slot. A round-robin arbiter moves held words into a
//   show-ahead FIFO for the host link. Words pass through unmodified.
//
// Ports
//   clk, nreset      clock, synchronous active-low reset
//   en               capture / arbitration enable (read side ignores it)
//   in_word          NCH*W coder words, channel i on [i*W +: W]
//   in_ready         NCH coder ready levels; a rising level captures a word
//   out_word         head-of-FIFO word (valid while out_valid)
//   out_valid        FIFO non-empty
//   out_ack          consumer pops out_word this cycle
//   fifo_level       words held in the FIFO, 0..DEPTH
//   overflow         sticky, a word was dropped
//   drop_cnt         saturating count of drop events
//   clear_ovf        clears overflow / drop_cnt (a same-cycle drop wins)

// Per-channel capture slot: edge detect plus a one-word holding register.
module rle_chan_slot #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         en,
    input  logic         in_ready,
    input  logic [W-1:0] in_word,
    input  logic         grant,
    output logic [W-1:0] hold_word,
    output logic         hold_v,
    output logic         drop
);
    logic prev_ready;
    logic rise;

    assign rise = in_ready & ~prev_ready & en;
    // A grant empties the slot this same edge, so a rise then refills it
    // instead of dropping.
    assign drop = rise & hold_v & ~grant;

    always_ff @(posedge clk) begin
        // prev_ready tracks in_ready even during reset, so a ready level that
        // is already high at reset release counts as seen and is not captured.
        prev_ready <= in_ready;
        if (!nreset) begin
            hold_word <= '0;
            hold_v    <= 1'b0;
        end else if (rise && (!hold_v || grant)) begin
            hold_word <= in_word;
            hold_v    <= 1'b1;
        end else if (grant) begin
            hold_v    <= 1'b0;
        end
    end
endmodule

module rle_word_collector #(
    parameter int NCH   = 4,
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en,
    input  logic [NCH*W-1:0] in_word,
    input  logic [NCH-1:0]   in_ready,
    output logic [W-1:0]     out_word,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [AW:0]      fifo_level,
    output logic             overflow,
    output logic [7:0]       drop_cnt,
    input  logic             clear_ovf
);
    localparam int RRW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW  = AW + 1;

    logic [NCH-1:0][W-1:0] hold_word;
    logic [NCH-1:0]        hold_v;
    logic [NCH-1:0]        drop;
    logic [NCH-1:0]        grant;

    logic [RRW-1:0]        rr;
    logic [RRW-1:0]        gnt_idx;
    logic                  gnt_any;

    logic [W-1:0]          mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  full;
    logic                  wr;
    logic                  rd;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_slot
            rle_chan_slot #(.W(W)) u_slot (
                .clk       (clk),
                .nreset    (nreset),
                .en        (en),
                .in_ready  (in_ready[g]),
                .in_word   (in_word[g*W +: W]),
                .grant     (grant[g]),
                .hold_word (hold_word[g]),
                .hold_v    (hold_v[g]),
                .drop      (drop[g])
            );
        end
    endgenerate

    // Round-robin pick: first held slot at or above rr, otherwise the first
    // held slot from 0 (the wrapped part of the scan).
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        grant   = '0;
        if (en && !full) begin
            for (int j = 0; j < NCH; j++) begin
                if (!gnt_any && hold_v[j] && j >= int'(rr)) begin
                    gnt_any = 1'b1;
                    gnt_idx = RRW'(j);
                end
            end
            for (int j = 0; j < NCH; j++) begin
                if (!gnt_any && hold_v[j]) begin
                    gnt_any = 1'b1;
                    gnt_idx = RRW'(j);
                end
            end
        end
        if (gnt_any)
            grant[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!nreset)
            rr <= '0;
        else if (gnt_any)
            rr <= (gnt_idx == RRW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Show-ahead FIFO. Write is gated on the registered full flag, so a pop
    // at full does not make room for a write until the following cycle.
    assign full      = (fifo_level == LW'(DEPTH));
    assign out_valid = (fifo_level != '0);
    assign out_word  = mem[rd_ptr];
    assign wr        = gnt_any;
    assign rd        = out_valid & out_ack;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= hold_word[gnt_idx];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Simultaneous drops on several channels count as one event.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (|drop) begin
            overflow <= 1'b1;
            if (clear_ovf)
                drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_rle_word_collector.sv
// Directed bench for rle_word_collector: single word, round-robin order,
// FIFO full / drop, read-at-full, en gating, and mid-stream reset.
module tb_rle_word_collector;
    localparam int NCH   = 4;
    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             nreset;
    logic             en;
    logic [NCH*W-1:0] in_word;
    logic [NCH-1:0]   in_ready;
    logic [W-1:0]     out_word;
    logic             out_valid;
    logic             out_ack;
    logic [AW:0]      fifo_level;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic             clear_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rle_word_collector #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .en         (en),
        .in_word    (in_word),
        .in_ready   (in_ready),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .clear_ovf  (clear_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop(input string tag, input logic [15:0] exp);
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " word"}, 32'(out_word), 32'(exp));
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    // One-cycle ready pulse: captured at the first edge, granted at the next.
    task automatic pulse(input int ch, input logic [15:0] word);
        in_word[ch*W +: W] = word;
        in_ready[ch]       = 1'b1;
        tick();
        in_ready[ch]       = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
    endtask

    initial begin
        nreset    = 1'b0;
        en        = 1'b0;
        in_word   = '0;
        in_ready  = '0;
        out_ack   = 1'b0;
        clear_ovf = 1'b0;
        tick();
        tick();
        chk("rst valid", 32'(out_valid), 32'd0);
        chk("rst level", 32'(fifo_level), 32'd0);
        chk("rst ovf", 32'(overflow), 32'd0);
        chk("rst dcnt", 32'(drop_cnt), 32'd0);
        chk("rst word", 32'(out_word), 32'd0);
        nreset = 1'b1;
        en     = 1'b1;
        tick();

        // Single word, ready held high for three edges.
        in_word[2*W +: W] = 16'hA5C3;
        in_ready[2]       = 1'b1;
        tick();
        chk("single early valid", 32'(out_valid), 32'd0);
        tick();
        chk("single valid", 32'(out_valid), 32'd1);
        chk("single word", 32'(out_word), 32'hA5C3);
        chk("single level", 32'(fifo_level), 32'd1);
        tick();
        in_ready[2] = 1'b0;
        tick();
        tick();
        chk("single once", 32'(fifo_level), 32'd1);
        pop("single pop", 16'hA5C3);
        chk("single drained", 32'(fifo_level), 32'd0);
        chk("single empty", 32'(out_valid), 32'd0);

        // Fairness from rr = 0, twice.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NCH; i++)
                in_word[i*W +: W] = 16'(16'h8001 + i);
            in_ready = '1;
            tick();
            in_ready = '0;
            for (int i = 0; i < NCH; i++)
                tick();
            chk("rr0 level", 32'(fifo_level), 32'd4);
            pop("rr0 a", 16'h8001);
            pop("rr0 b", 16'h8002);
            pop("rr0 c", 16'h8003);
            pop("rr0 d", 16'h8004);
        end
        // A ch1 grant moves rr to 2.
        pulse(1, 16'h8102);
        pop("rr ch1", 16'h8102);
        for (int i = 0; i < NCH; i++)
            in_word[i*W +: W] = 16'(16'h9001 + i);
        in_ready = '1;
        tick();
        in_ready = '0;
        for (int i = 0; i < NCH; i++)
            tick();
        pop("rr2 a", 16'h9003);
        pop("rr2 b", 16'h9004);
        pop("rr2 c", 16'h9001);
        pop("rr2 d", 16'h9002);

        // Full FIFO: 16 buffered, 1 held, 1 dropped.
        do_reset();
        for (int k = 0; k < 18; k++)
            pulse(0, 16'(16'h1000 + k));
        chk("full level", 32'(fifo_level), 32'd16);
        chk("full hold_v", 32'(dut.hold_v[0]), 32'd1);
        chk("full ovf", 32'(overflow), 32'd1);
        chk("full dcnt", 32'(drop_cnt), 32'd1);
        // Pop at full: no write on that edge, the pending hold lands next.
        pop("full pop0", 16'h1000);
        chk("rdwr level15", 32'(fifo_level), 32'd15);
        chk("rdwr held", 32'(dut.hold_v[0]), 32'd1);
        tick();
        chk("rdwr level16", 32'(fifo_level), 32'd16);
        chk("rdwr hold clr", 32'(dut.hold_v[0]), 32'd0);
        for (int k = 1; k < 17; k++)
            pop($sformatf("full pop%0d", k), 16'(16'h1000 + k));
        chk("full drained", 32'(fifo_level), 32'd0);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("ack empty", 32'(fifo_level), 32'd0);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("clr ovf", 32'(overflow), 32'd0);
        chk("clr dcnt", 32'(drop_cnt), 32'd0);

        // en gating: rise while disabled is never captured; read side drains.
        pulse(3, 16'h7777);
        chk("en pre level", 32'(fifo_level), 32'd1);
        en                = 1'b0;
        in_word[1*W +: W] = 16'h1111;
        in_ready[1]       = 1'b1;
        tick();
        tick();
        en = 1'b1;
        tick();
        tick();
        chk("en no capture", 32'(fifo_level), 32'd1);
        en = 1'b0;
        pop("en drain", 16'h7777);
        chk("en drained", 32'(fifo_level), 32'd0);
        in_ready[1] = 1'b0;
        en          = 1'b1;
        tick();

        // Reset mid-stream, with ch2 ready high across reset release.
        for (int k = 0; k < 5; k++)
            pulse(0, 16'(16'h2000 + k));
        chk("mid level", 32'(fifo_level), 32'd5);
        in_ready[2] = 1'b1;
        do_reset();
        chk("mid rst level", 32'(fifo_level), 32'd0);
        chk("mid rst valid", 32'(out_valid), 32'd0);
        chk("mid rst ovf", 32'(overflow), 32'd0);
        tick();
        tick();
        chk("mid seen ready", 32'(fifo_level), 32'd0);
        in_ready[2] = 1'b0;
        tick();
        pulse(1, 16'h5A5A);
        chk("mid fresh level", 32'(fifo_level), 32'd1);
        pop("mid fresh", 16'h5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
